// File: rtl/dmg_cart_pkg.sv
// ============================================================================
// Module      : dmg_cart_pkg
// Description : Shared types and constants for the MBC1 cartridge responder.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package dmg_cart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_WR_LOW = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RGN_ROM0 = 2'd0,
        RGN_ROMX = 2'd1,
        RGN_XRAM = 2'd2,
        RGN_NONE = 2'd3
    } region_t;

    // MBC register windows; only address bits [15:13] select among them
    localparam logic [15:0] c_base_ram_en  = 16'h0000;
    localparam logic [15:0] c_base_bank_lo = 16'h2000;
    localparam logic [15:0] c_base_bank_hi = 16'h4000;
    localparam logic [15:0] c_base_mode    = 16'h6000;
    localparam logic [15:0] c_base_xram    = 16'hA000;

    localparam logic [3:0]  c_ram_en_magic = 4'hA;

    function automatic region_t decode_region(input logic [15:0] addr);
        region_t rgn;
        if (addr[15:14] == 2'b00)
            rgn = RGN_ROM0;
        else if (addr[15:14] == 2'b01)
            rgn = RGN_ROMX;
        else if (addr[15:13] == c_base_xram[15:13])
            rgn = RGN_XRAM;
        else
            rgn = RGN_NONE;
        return rgn;
    endfunction

    // Only a written value of zero is remapped; the upper bank bits are untouched
    function automatic logic [4:0] bank_lo_fix(input logic [4:0] val);
        return (val == 5'd0) ? 5'd1 : val;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ext_bus_sync.sv
// ============================================================================
// Module      : ext_bus_sync
// Description : Two-flop synchroniser for a group of asynchronous bus pins.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ext_bus_sync #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/ext_bus_cart_mbc1.sv
// ============================================================================
// Module      : ext_bus_cart_mbc1
// Description : MBC1 cartridge responder on the external CPU bus pins.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ext_bus_cart_mbc1 #(
    parameter int ROM_AW = 21,
    parameter int RAM_AW = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       a,
    input  logic [7:0]        d_in,
    output logic [7:0]        d_out,
    output logic              d_oe,
    input  logic              nrd,
    input  logic              nwr,
    input  logic              ncs,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_rdata,
    output logic [RAM_AW-1:0] ram_addr,
    input  logic [7:0]        ram_rdata,
    output logic [7:0]        ram_wdata,
    output logic              ram_we
);

    import dmg_cart_pkg::*;

    // ------------------------------------------------------------------
    // Pin synchronisation
    // ------------------------------------------------------------------
    logic [2:0]  w_strb_s;
    logic [15:0] w_a_s;
    logic [7:0]  w_d_s;
    logic        w_nrd_s;
    logic        w_nwr_s;
    logic        w_ncs_s;

    ext_bus_sync #(.WIDTH(3), .RESET_VAL(3'b111)) u_sync_strb (
        .clk   (clk),
        .reset (reset),
        .i_d   ({ncs, nwr, nrd}),
        .o_q   (w_strb_s)
    );

    ext_bus_sync #(.WIDTH(16), .RESET_VAL(16'h0000)) u_sync_addr (
        .clk   (clk),
        .reset (reset),
        .i_d   (a),
        .o_q   (w_a_s)
    );

    ext_bus_sync #(.WIDTH(8), .RESET_VAL(8'h00)) u_sync_data (
        .clk   (clk),
        .reset (reset),
        .i_d   (d_in),
        .o_q   (w_d_s)
    );

    assign w_nrd_s = w_strb_s[0];
    assign w_nwr_s = w_strb_s[1];
    assign w_ncs_s = w_strb_s[2];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_next_state;

    logic        r_ram_en;
    logic [4:0]  r_bank_lo;
    logic [1:0]  r_bank_hi;
    logic        r_mode;

    logic [15:0] r_wr_a;
    logic [7:0]  r_wr_d;
    logic        r_wr_ncs;

    logic        r_rd_ok;
    logic        r_rd_xram;
    logic        r_d_oe;
    logic [7:0]  r_d_out;

    region_t     w_rgn;
    logic        w_rgn_ok;
    logic [1:0]  w_rom_upper;
    logic [4:0]  w_rom_mid;
    logic [20:0] w_rom_full;
    logic [15:0] w_ram_src_a;
    logic [14:0] w_ram_full;

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    // A pending write always wins over a read so that a strobe overlap
    // never drives the bus while the CPU is also driving it.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_nwr_s)
                    w_next_state = ST_WR_LOW;
                else if (!w_nrd_s)
                    w_next_state = ST_READ;
            end
            ST_READ: begin
                if (!w_nwr_s)
                    w_next_state = ST_WR_LOW;
                else if (w_nrd_s)
                    w_next_state = ST_IDLE;
            end
            ST_WR_LOW: begin
                if (w_nwr_s)
                    w_next_state = ST_COMMIT;
            end
            ST_COMMIT: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Read address generation
    // ------------------------------------------------------------------
    always_comb begin
        w_rgn       = decode_region(w_a_s);
        w_rgn_ok    = (w_rgn == RGN_ROM0) || (w_rgn == RGN_ROMX) ||
                      ((w_rgn == RGN_XRAM) && !w_ncs_s && r_ram_en);
        w_rom_upper = (w_a_s[14] || r_mode) ? r_bank_hi : 2'b00;
        w_rom_mid   = w_a_s[14] ? r_bank_lo : 5'd0;
        w_rom_full  = {w_rom_upper, w_rom_mid, w_a_s[13:0]};
        // The commit cycle addresses RAM from the captured write, not the live pins
        w_ram_src_a = (r_state == ST_COMMIT) ? r_wr_a : w_a_s;
        w_ram_full  = {(r_mode ? r_bank_hi : 2'b00), w_ram_src_a[12:0]};
    end

    assign rom_addr = w_rom_full[ROM_AW-1:0];
    assign ram_addr = w_ram_full[RAM_AW-1:0];

    // ------------------------------------------------------------------
    // Read data path: rdata lags the presented address by one cycle, so the
    // region qualifier is delayed by one cycle to stay aligned with it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ok   <= 1'b0;
            r_rd_xram <= 1'b0;
            r_d_oe    <= 1'b0;
            r_d_out   <= 8'h00;
        end else begin
            r_rd_ok   <= w_rgn_ok;
            r_rd_xram <= (w_rgn == RGN_XRAM);
            r_d_oe    <= (r_state == ST_READ) && (w_next_state == ST_READ) && r_rd_ok;
            if (r_state == ST_READ)
                r_d_out <= r_rd_xram ? ram_rdata : rom_rdata;
        end
    end

    assign d_oe  = r_d_oe;
    assign d_out = r_d_out;

    // ------------------------------------------------------------------
    // Write capture and commit
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_a   <= 16'h0000;
            r_wr_d   <= 8'h00;
            r_wr_ncs <= 1'b1;
        end else if (r_state == ST_WR_LOW) begin
            r_wr_a   <= w_a_s;
            r_wr_d   <= w_d_s;
            r_wr_ncs <= w_ncs_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ram_en  <= 1'b0;
            r_bank_lo <= 5'd1;
            r_bank_hi <= 2'b00;
            r_mode    <= 1'b0;
        end else if (r_state == ST_COMMIT) begin
            case (r_wr_a[15:13])
                c_base_ram_en[15:13]:  r_ram_en  <= (r_wr_d[3:0] == c_ram_en_magic);
                c_base_bank_lo[15:13]: r_bank_lo <= bank_lo_fix(r_wr_d[4:0]);
                c_base_bank_hi[15:13]: r_bank_hi <= r_wr_d[1:0];
                c_base_mode[15:13]:    r_mode    <= r_wr_d[0];
                default: ;
            endcase
        end
    end

    // Gated by reset so a commit coinciding with reset never reaches the RAM
    assign ram_we    = (r_state == ST_COMMIT) && !reset && !r_wr_ncs && r_ram_en &&
                       (r_wr_a[15:13] == c_base_xram[15:13]);
    assign ram_wdata = r_wr_d;

endmodule

`default_nettype wire

// File: tb/tb_ext_bus_cart_mbc1.sv
// ============================================================================
// Module      : tb_ext_bus_cart_mbc1
// Description : Self-checking bench for the MBC1 cartridge bus responder.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ext_bus_cart_mbc1;

    localparam int ROM_AW = 21;
    localparam int RAM_AW = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic [15:0]       a;
    logic [7:0]        d_in;
    logic [7:0]        d_out;
    logic              d_oe;
    logic              nrd;
    logic              nwr;
    logic              ncs;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_rdata;
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_rdata;
    logic [7:0]        ram_wdata;
    logic              ram_we;

    always #5 clk = ~clk;

    ext_bus_cart_mbc1 #(.ROM_AW(ROM_AW), .RAM_AW(RAM_AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .d_in      (d_in),
        .d_out     (d_out),
        .d_oe      (d_oe),
        .nrd       (nrd),
        .nwr       (nwr),
        .ncs       (ncs),
        .rom_addr  (rom_addr),
        .rom_rdata (rom_rdata),
        .ram_addr  (ram_addr),
        .ram_rdata (ram_rdata),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we)
    );

    // Backing memories: ROM contents are a hash of the byte address
    function automatic logic [7:0] rom_byte(input logic [20:0] ad);
        logic [31:0] h;
        h = {11'd0, ad} * 32'h9E3779B1;
        return h[23:16] ^ ad[7:0];
    endfunction

    logic [7:0] bram [0:(1<<RAM_AW)-1];

    always @(posedge clk) begin
        rom_rdata <= rom_byte(rom_addr);
        ram_rdata <= bram[ram_addr];
        if (ram_we)
            bram[ram_addr] <= ram_wdata;
    end

    // Behavioural cartridge model
    bit         m_ram_en;
    int         m_lo;
    int         m_hi;
    bit         m_mode;
    logic [7:0] m_ram [0:(1<<RAM_AW)-1];

    task automatic model_reset();
        m_ram_en = 1'b0;
        m_lo     = 1;
        m_hi     = 0;
        m_mode   = 1'b0;
    endtask

    function automatic bit in_xram(input logic [15:0] ad);
        return (ad >= 16'hA000) && (ad < 16'hC000);
    endfunction

    function automatic int rom_index(input logic [15:0] ad);
        if (ad < 16'h4000)
            return (m_mode ? m_hi * 32 : 0) * 16384 + int'(ad);
        return (m_hi * 32 + m_lo) * 16384 + int'(ad) % 16384;
    endfunction

    function automatic int ram_index(input logic [15:0] ad);
        return (m_mode ? m_hi : 0) * 8192 + int'(ad) % 8192;
    endfunction

    task automatic model_write(input logic [15:0] ad, input logic [7:0] dv, input logic nc);
        if (ad < 16'h2000)
            m_ram_en = (dv % 16 == 10);
        else if (ad < 16'h4000)
            m_lo = (dv % 32 == 0) ? 1 : int'(dv) % 32;
        else if (ad < 16'h6000)
            m_hi = int'(dv) % 4;
        else if (ad < 16'h8000)
            m_mode = dv[0];
        else if (in_xram(ad) && !nc && m_ram_en)
            m_ram[ram_index(ad)] = dv;
    endtask

    // Scoreboard bookkeeping
    int         checks = 0;
    int         passes = 0;
    bit         rd_window = 1'b0;
    bit         exp_valid = 1'b0;
    logic [7:0] exp_byte  = 8'h00;
    bit         wr_window = 1'b0;
    int         we_seen   = 0;
    logic [14:0] exp_we_addr = '0;
    logic [7:0]  exp_we_data = '0;
    logic [14:0] last_we_addr = '0;
    logic [7:0]  last_we_data = '0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (ok)
            passes++;
        else
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    // Per-cycle compare against the model
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && d_oe)
                chk(rd_window && exp_valid && (d_out == exp_byte), "d_out_drive",
                    {23'd0, d_oe, d_out}, {23'd0, exp_valid, exp_byte});
            if (ram_we) begin
                we_seen++;
                last_we_addr = ram_addr;
                last_we_data = ram_wdata;
                chk(wr_window && (ram_addr == exp_we_addr) && (ram_wdata == exp_we_data), "ram_we_pulse",
                    {9'd0, ram_addr, ram_wdata}, {9'd0, exp_we_addr, exp_we_data});
            end
        end
    end

    task automatic bus_write(input logic [15:0] ad, input logic [7:0] dv, input logic nc);
        bit exp_pulse;
        exp_pulse   = in_xram(ad) && !nc && m_ram_en;
        exp_we_addr = 15'(ram_index(ad));
        exp_we_data = dv;
        wr_window   = exp_pulse;
        we_seen     = 0;
        @(posedge clk); #1;
        a = ad; d_in = dv; ncs = nc; nwr = 1'b0;
        repeat (3) @(posedge clk);
        #1 nwr = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk(we_seen == (exp_pulse ? 1 : 0), "ram_we_count", we_seen, {31'd0, exp_pulse});
        wr_window = 1'b0;
        ncs = 1'b1;
        model_write(ad, dv, nc);
    endtask

    task automatic bus_read(input logic [15:0] ad, input logic nc, output logic [20:0] ra_seen);
        bit is_rom;
        is_rom    = (ad < 16'h8000);
        exp_valid = is_rom || (in_xram(ad) && !nc && m_ram_en);
        exp_byte  = is_rom ? rom_byte(21'(rom_index(ad))) : m_ram[ram_index(ad)];
        @(posedge clk); #1;
        a = ad; ncs = nc; nrd = 1'b0; rd_window = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        ra_seen = rom_addr;
        chk(d_oe == exp_valid, "d_oe_read", {31'd0, d_oe}, {31'd0, exp_valid});
        if (is_rom)
            chk(rom_addr == 21'(rom_index(ad)), "rom_addr", {11'd0, rom_addr}, rom_index(ad));
        else if (exp_valid)
            chk(ram_addr == 15'(ram_index(ad)), "ram_addr", {17'd0, ram_addr}, ram_index(ad));
        @(posedge clk); #1 nrd = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk(d_oe == 1'b0, "d_oe_release", {31'd0, d_oe}, 32'd0);
        rd_window = 1'b0;
        ncs = 1'b1;
    endtask

    logic [20:0] ra;
    logic [7:0]  dv;
    logic [15:0] ad;
    int          op;

    initial begin
        for (int i = 0; i < (1 << RAM_AW); i++) begin
            bram[i]  = 8'h00;
            m_ram[i] = 8'h00;
        end
        reset = 1'b1; a = 16'h0000; d_in = 8'h00; nrd = 1'b1; nwr = 1'b1; ncs = 1'b1;
        model_reset();
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk(d_oe == 1'b0,    "reset_d_oe",   {31'd0, d_oe},   32'd0);
        chk(ram_we == 1'b0,  "reset_ram_we", {31'd0, ram_we}, 32'd0);
        chk(d_out == 8'h00,  "reset_d_out",  {24'd0, d_out},  32'd0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);

        // Directed scenarios with hand-computed addresses
        bus_read(16'h0150, 1'b1, ra);
        chk(ra == 21'h000150, "lit_rom0", {11'd0, ra}, 32'h000150);
        bus_write(16'h2000, 8'h00, 1'b1);
        bus_read(16'h4000, 1'b1, ra);
        chk(ra == 21'h004000, "lit_bank0_to_1", {11'd0, ra}, 32'h004000);
        bus_write(16'h2000, 8'h05, 1'b1);
        bus_read(16'h4000, 1'b1, ra);
        chk(ra == 21'h014000, "lit_bank5", {11'd0, ra}, 32'h014000);
        bus_write(16'h4000, 8'h02, 1'b1);
        bus_write(16'h6000, 8'h01, 1'b1);
        bus_read(16'h1000, 1'b1, ra);
        chk(ra == 21'h101000, "lit_mode1_rom0", {11'd0, ra}, 32'h101000);
        bus_write(16'h6000, 8'h00, 1'b1);
        bus_read(16'h1000, 1'b1, ra);
        chk(ra == 21'h001000, "lit_mode0_rom0", {11'd0, ra}, 32'h001000);

        bus_write(16'h0000, 8'h0A, 1'b1);
        bus_write(16'hA123, 8'h5A, 1'b0);
        chk(last_we_addr == 15'h0123, "lit_ram_addr", {17'd0, last_we_addr}, 32'h0123);
        chk(last_we_data == 8'h5A, "lit_ram_wdata", {24'd0, last_we_data}, 32'h5A);
        bus_read(16'hA123, 1'b0, ra);
        bus_write(16'h0000, 8'h00, 1'b1);
        bus_write(16'hA123, 8'hC3, 1'b0);
        bus_read(16'hA123, 1'b0, ra);

        // Overlapping strobes: the write wins and the bus is never driven
        we_seen = 0;
        @(posedge clk); #1;
        a = 16'h2000; d_in = 8'h03; nrd = 1'b0; nwr = 1'b0;
        repeat (4) @(posedge clk);
        #1 nrd = 1'b1; nwr = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk(we_seen == 0, "overlap_no_we", we_seen, 32'd0);
        model_write(16'h2000, 8'h03, 1'b1);
        bus_read(16'h4000, 1'b1, ra);
        chk(ra == 21'h10C000, "lit_overlap_bank3", {11'd0, ra}, 32'h10C000);

        // Zero in the low bank field maps to 1 while the high bits still apply
        bus_write(16'h4000, 8'h01, 1'b1);
        bus_write(16'h2000, 8'h20, 1'b1);
        bus_read(16'h4000, 1'b1, ra);
        chk(ra == 21'h084000, "lit_bank21", {11'd0, ra}, 32'h084000);

        // Reset while a bank write is held low: the write must be lost
        we_seen = 0;
        @(posedge clk); #1;
        a = 16'h2000; d_in = 8'h1F; nwr = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1; nwr = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk(d_oe == 1'b0, "reset_mid_d_oe", {31'd0, d_oe}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        model_reset();
        repeat (4) @(posedge clk);
        chk(we_seen == 0, "reset_mid_no_we", we_seen, 32'd0);
        bus_read(16'h4000, 1'b1, ra);
        chk(ra == 21'h004000, "lit_reset_bank1", {11'd0, ra}, 32'h004000);

        // Randomised transactions against the model
        for (int n = 0; n < 200; n++) begin
            op = int'($urandom_range(0, 9));
            dv = 8'($urandom);
            case (op)
                0: begin
                    if ($urandom_range(0, 2) != 0) dv[3:0] = 4'hA;
                    bus_write(16'($urandom_range(16'h0000, 16'h1FFF)), dv, 1'b1);
                end
                1: bus_write(16'($urandom_range(16'h2000, 16'h3FFF)), dv, 1'b1);
                2: bus_write(16'($urandom_range(16'h4000, 16'h5FFF)), dv, 1'b1);
                3: bus_write(16'($urandom_range(16'h6000, 16'h7FFF)), dv, 1'b1);
                4, 5: bus_write(16'($urandom_range(16'hA000, 16'hBFFF)), dv,
                                ($urandom_range(0, 3) == 0));
                6, 7: bus_read(16'($urandom_range(16'h0000, 16'h7FFF)), 1'b1, ra);
                8: bus_read(16'($urandom_range(16'hA000, 16'hBFFF)), ($urandom_range(0, 3) == 0), ra);
                default: begin
                    ad = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(16'h8000, 16'h9FFF))
                                                     : 16'($urandom_range(16'hC000, 16'hFFFF));
                    bus_read(ad, 1'($urandom_range(0, 1)), ra);
                end
            endcase
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
